ram16_ctrl: RTL and testbench

//  Initiator side of the 16x32 RAM port (en/read/address/in/out). Accepts burst

---
 rtl/ram16_ctrl_pkg.sv | 17 +
 rtl/ram16_ctrl_if.sv | 32 +++
 rtl/ram16_addr_cnt.sv | 37 +++
 rtl/ram16_ctrl.sv | 105 ++++++++++
 tb/tb_ram16_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram16_ctrl_pkg.sv
// Shared types and default widths for the ram16 burst controller.
package ram16_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    RD_HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/ram16_ctrl_if.sv
// CPU-side command / write-data / read-data channels of the ram16 burst controller.
interface ram16_ctrl_if
  import ram16_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready,
    input  req_ready, wd_ready, rd_valid, rd_data, done, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready,
    output req_ready, wd_ready, rd_valid, rd_data, done, err
  );
endinterface

// File: rtl/ram16_addr_cnt.sv
// Loadable burst address / remaining-word counter; the count holds at zero once exhausted.
module ram16_addr_cnt
  import ram16_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last,
  output logic              at_end
);
  logic [LEN_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      count    <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      count    <= load_len;
    end else if (step) begin
      cur_addr <= cur_addr + ADDR_W'(1);
      if (count != '0) count <= count - LEN_W'(1);
    end
  end

  assign last   = (count == '0);
  assign at_end = &cur_addr;

endmodule

// File: rtl/ram16_ctrl.sv
// Burst read/write initiator for the 16x32 ram16 array.
// Build option RAM16_CTRL_WRAP_EN: bursts wrap past address 15 instead of truncating there with err.
module ram16_ctrl
  import ram16_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ram16_ctrl_if.slave       bus,
  output logic              mem_en,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state, state_nxt;
  logic              req_hs, wd_hs, rd_hs;
  logic [ADDR_W-1:0] cur_addr;
  logic              last, at_end, final_word, trunc;

  assign req_hs = (state == IDLE)    && bus.req_valid;
  assign wd_hs  = (state == WR)      && bus.wd_valid;
  assign rd_hs  = (state == RD_HOLD) && bus.rd_ready;

  ram16_addr_cnt #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (req_hs),
    .load_addr (bus.req_addr),
    .load_len  (bus.req_len),
    .step      (wd_hs | rd_hs),
    .cur_addr  (cur_addr),
    .last      (last),
    .at_end    (at_end)
  );

`ifdef RAM16_CTRL_WRAP_EN
  assign final_word = last;
  assign trunc      = 1'b0 & at_end;
`else
  // Address 15 ends the burst early; a word still owed there marks the burst as truncated.
  assign final_word = last | at_end;
  assign trunc      = at_end & ~last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_hs) state_nxt = bus.req_write ? WR : RD_ADDR;
      WR:      if (wd_hs && final_word) state_nxt = DONE;
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RD_HOLD;
      RD_HOLD: if (rd_hs) state_nxt = final_word ? DONE : RD_ADDR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.done      = 1'b0;
    mem_en        = 1'b0;
    mem_read      = 1'b0;
    unique case (state)
      IDLE:    bus.req_ready = 1'b1;
      WR: begin
        bus.wd_ready = 1'b1;
        mem_en       = bus.wd_valid;
      end
      RD_ADDR: mem_read = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = cur_addr;
  assign mem_wdata = bus.wd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.err      <= 1'b0;
    end else begin
      if (state == RD_CAP) begin
        bus.rd_data  <= mem_rdata;
        bus.rd_valid <= 1'b1;
      end else if (rd_hs) begin
        bus.rd_valid <= 1'b0;
      end
      if ((wd_hs || rd_hs) && trunc) bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram16_ctrl.sv
// Self-checking bench for ram16_ctrl: behavioural RAM, spec-level expected memory and burst rules.
module tb_ram16_ctrl;
  import ram16_ctrl_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int LW = DEF_LEN_W;
`ifdef RAM16_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_en, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ram16_ctrl_if bus ();

  ram16_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .mem_en    (mem_en),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ram16: synchronous write on en, registered read on read.
  logic [DW-1:0] ram [16];
  wr_t           wr_log[$];
  int            rd_pulses = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      ram[mem_addr] <= mem_wdata;
      wr_log.push_back('{int'(mem_addr), mem_wdata});
    end
    if (mem_read) begin
      mem_rdata <= ram[mem_addr];
      rd_pulses <= rd_pulses + 1;
    end
  end

  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] wbuf [16];
  bit            exp_err;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  function automatic int burst_words(input int addr, input int len);
    if (!WRAP && addr + len > 15) return 16 - addr;
    return len + 1;
  endfunction

  task automatic do_write(input int addr, input int len, input int gap_mode, input string tag);
    int  n_exp = burst_words(addr, len);
    int  log0  = wr_log.size();
    int  idx = 0, cyc = 0, since = 0, bad = -1;
    bit  hs, seen_done = 0, busy_bad = 0, ok;
    wr_t exp_q[$];
    for (int i = 0; i < n_exp; i++) exp_q.push_back('{(addr + i) % 16, wbuf[i]});
    if (n_exp != len + 1) exp_err = 1'b1;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = AW'(addr); bus.req_len = LW'(len);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!seen_done && cyc < 200) begin
      if (bus.done) begin
        seen_done = 1'b1;
      end else begin
        if (bus.req_ready) busy_bad = 1'b1;
        bus.wd_valid = (idx <= len) &&
                       (gap_mode == 0 || (gap_mode == 1 && cyc % 3 == 0) ||
                        (gap_mode == 2 && $urandom_range(1, 0) == 1));
        bus.wd_data = (idx <= len) ? wbuf[idx] : '0;
        #1;
        hs = bus.wd_valid && bus.wd_ready;
        @(posedge clk);
        if (hs) begin idx++; since = 0; end
        else since++;
        @(negedge clk);
        cyc++;
      end
    end
    bus.wd_valid = 1'b0;

    total_cnt++;
    if (!seen_done) $display("FAIL %s done_seen: got none within 200 cycles, required a done pulse", tag);
    else pass_cnt++;
    if (seen_done) begin
      total_cnt++;
      if (since !== 0) $display("FAIL %s done_latency: got %0d idle edges after last word, required 0", tag, since);
      else pass_cnt++;
    end
    total_cnt++;
    if (idx !== n_exp) $display("FAIL %s wd_handshakes: got %0d, required %0d", tag, idx, n_exp);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad) $display("FAIL %s req_ready_busy: got 1 during burst, required 0", tag);
    else pass_cnt++;

    @(negedge clk);
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL %s done_width: got done=%b second cycle, required 0", tag, bus.done);
    else pass_cnt++;

    ok = (wr_log.size() - log0 == n_exp);
    for (int i = 0; i < n_exp && ok; i++)
      if (wr_log[log0+i].addr != exp_q[i].addr || wr_log[log0+i].data !== exp_q[i].data) begin
        ok = 1'b0; bad = i;
      end
    total_cnt++;
    if (!ok) begin
      if (bad < 0)
        $display("FAIL %s mem_writes: got %0d mem_en pulses, required %0d", tag, wr_log.size() - log0, n_exp);
      else
        $display("FAIL %s mem_write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h", tag, bad,
                 wr_log[log0+bad].addr, wr_log[log0+bad].data, exp_q[bad].addr, exp_q[bad].data);
    end else pass_cnt++;

    total_cnt++;
    if (bus.err !== exp_err) $display("FAIL %s err: got %b, required %b", tag, bus.err, exp_err);
    else pass_cnt++;

    foreach (exp_q[i]) exp_mem[exp_q[i].addr] = exp_q[i].data;
  endtask

  task automatic do_read(input int addr, input int len, input int stall, input string tag);
    int          n_exp = burst_words(addr, len);
    int          rp0 = rd_pulses;
    int          k, a, stalls;
    bit          stable;
    logic [DW-1:0] held;
    if (n_exp != len + 1) exp_err = 1'b1;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = AW'(addr); bus.req_len = LW'(len);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int w = 0; w < n_exp; w++) begin
      a = (addr + w) % 16;
      k = 1;
      while (!bus.rd_valid && k < 20) begin @(negedge clk); k++; end
      if (!bus.rd_valid) begin
        total_cnt++;
        $display("FAIL %s rd_valid[%0d]: got 0 after 20 cycles, required 1", tag, w);
        break;
      end
      if (w == 0) begin
        total_cnt++;
        if (k - 1 != 2) $display("FAIL %s rd_latency: got %0d cycles, required 2", tag, k - 1);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus.rd_data !== exp_mem[a])
        $display("FAIL %s rd_data[addr %0d]: got %h, required %h", tag, a, bus.rd_data, exp_mem[a]);
      else pass_cnt++;
      stalls = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
      held = bus.rd_data;
      stable = 1'b1;
      repeat (stalls) begin
        @(negedge clk);
        if (!bus.rd_valid || bus.rd_data !== held) stable = 1'b0;
      end
      if (stalls > 0) begin
        total_cnt++;
        if (!stable) $display("FAIL %s rd_hold[addr %0d]: got valid=%b data=%h, required valid=1 data=%h",
                              tag, a, bus.rd_valid, bus.rd_data, held);
        else pass_cnt++;
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end

    k = 0;
    while (!bus.done && k < 10) begin @(negedge clk); k++; end
    total_cnt++;
    if (k !== 0) $display("FAIL %s rd_done: got done after %0d extra cycles, required 0", tag, k);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rd_pulses - rp0 !== n_exp)
      $display("FAIL %s mem_read_count: got %0d, required %0d", tag, rd_pulses - rp0, n_exp);
    else pass_cnt++;
    total_cnt++;
    if (bus.err !== exp_err) $display("FAIL %s err: got %b, required %b", tag, bus.err, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.req_ready, bus.wd_ready, bus.rd_valid, bus.done, mem_en, mem_read, bus.err} !== 7'b1000000)
      $display("FAIL reset_ctrl: got rr/wr/rv/dn/en/rd/err=%b, required 1000000",
               {bus.req_ready, bus.wd_ready, bus.rd_valid, bus.done, mem_en, mem_read, bus.err});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== '0 || bus.rd_data !== '0)
      $display("FAIL reset_data: got mem_addr=%0d rd_data=%h, required 0 and 0", mem_addr, bus.rd_data);
    else pass_cnt++;
    rst_n = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic test_single_write();
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(3, 0, 0, "single_wr");
    do_read(3, 0, 0, "single_rd");
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < 16; i++) wbuf[i] = DW'(i * 32'h11);
    do_write(0, 15, 0, "full_wr");
    do_read(0, 15, 0, "full_rd");
  endtask

  task automatic test_read_stall();
    do_read(4, 2, 5, "stall_rd");
  endtask

  task automatic test_wrap_trunc();
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    do_write(14, 3, 0, "edge_wr");
    do_read(14, 1, 0, "edge_rd");
  endtask

  task automatic test_wd_gaps();
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    do_write(5, 4, 1, "gap_wr");
    do_read(5, 4, 0, "gap_rd");
  endtask

  task automatic test_random();
    int a, l;
    for (int it = 0; it < 10; it++) begin
      a = int'($urandom_range(15, 0));
      l = int'($urandom_range(15, 0));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      if ($urandom_range(1, 0) == 1) do_write(a, l, 2, "rand_wr");
      else                            do_read(a, l, -1, "rand_rd");
    end
  endtask

  task automatic test_reset_mid_burst();
    int log0 = wr_log.size();
    int idx = 0, cyc = 0;
    bit hs;
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = '0; bus.req_len = LW'(7);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (idx < 2 && cyc < 20) begin
      bus.wd_valid = 1'b1; bus.wd_data = wbuf[idx];
      #1;
      hs = bus.wd_ready;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.wd_valid = 1'b1; bus.wd_data = wbuf[2];
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.wd_ready, bus.rd_valid, bus.done, mem_en, mem_read, bus.err} !== 7'b1000000)
      $display("FAIL midrst_ctrl: got rr/wr/rv/dn/en/rd/err=%b, required 1000000",
               {bus.req_ready, bus.wd_ready, bus.rd_valid, bus.done, mem_en, mem_read, bus.err});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== '0 || bus.rd_data !== '0)
      $display("FAIL midrst_data: got mem_addr=%0d rd_data=%h, required 0 and 0", mem_addr, bus.rd_data);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.wd_valid = 1'b0;
    exp_err = 1'b0;
    exp_mem[0] = wbuf[0];
    exp_mem[1] = wbuf[1];
    total_cnt++;
    if (wr_log.size() - log0 !== 2)
      $display("FAIL midrst_writes: got %0d mem_en pulses, required 2", wr_log.size() - log0);
    else pass_cnt++;
    do_read(0, 7, 0, "midrst_rd");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    exp_err = 1'b0;
    test_reset();
    test_single_write();
    test_full_burst();
    test_read_stall();
    test_wrap_trunc();
    test_wd_gaps();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
